// File: rtl/life_stats_display.sv
`default_nettype none
//============================================================================
// Module      : life_stats_display
// Description : Statistics front-end for the 16x16 green cell grid.
//               Snapshots the grid, serially counts live cells, converts the
//               count to BCD with a sequential double-dabble and shows it on
//               HEX2..HEX0 (leading zeros blanked).  A free-standing 3-digit
//               decimal generation counter, advanced by gen_tick unless
//               SW_pause is set, is shown on HEX5..HEX3.
//
// Ports       : clk          system clock
//               reset        asynchronous active-high reset
//               SW_pause     1 = ignore gen_tick
//               gen_tick     one pulse per grid generation step
//               GrnPixels    [row][col] live-cell grid, 1 = alive
//               HEX0..HEX2   population ones/tens/hundreds, active-low gfedcba
//               HEX3..HEX5   generation ones/tens/hundreds, active-low gfedcba
//               stats_valid  set once the first population result is latched
//
// Revision    : 1.0 - initial release
//============================================================================
module life_stats_display (
    input  logic               clk,
    input  logic               reset,
    input  logic               SW_pause,
    input  logic               gen_tick,
    input  logic [15:0][15:0]  GrnPixels,
    output logic [6:0]         HEX0,
    output logic [6:0]         HEX1,
    output logic [6:0]         HEX2,
    output logic [6:0]         HEX3,
    output logic [6:0]         HEX4,
    output logic [6:0]         HEX5,
    output logic               stats_valid
);

    //------------------------------------------------------------------------
    // Constants
    //------------------------------------------------------------------------
    localparam logic [7:0] c_LAST_IDX   = 8'd255;  // final cell of the scan
    localparam logic [3:0] c_LAST_SHIFT = 4'd8;    // ninth double-dabble shift
    localparam logic [6:0] c_SEG_BLANK  = 7'b1111111;

    //------------------------------------------------------------------------
    // Population FSM
    //------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_CAPTURE = 2'd0,
        S_COUNT   = 2'd1,
        S_CONVERT = 2'd2,
        S_UPDATE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [15:0][15:0] r_snap;      // frame snapshot of GrnPixels
    logic [8:0]        r_count;     // live-cell count, later the dabble shifter
    logic [7:0]        r_idx;       // scan index; low nibble reused as shift count
    logic [11:0]       r_bcd;       // double-dabble scratch {hund, tens, ones}
    logic [11:0]       r_disp;      // latched population digits
    logic              r_valid;

    logic              w_cell;
    logic [11:0]       w_bcd_adj;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_CAPTURE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_CAPTURE: w_state_next = S_COUNT;
            S_COUNT: begin
                if (r_idx == c_LAST_IDX) begin
                    w_state_next = S_CONVERT;
                end
            end
            S_CONVERT: begin
                // r_idx wrapped to 0 at the end of COUNT, so its low nibble
                // counts the shifts 0..8 here.
                if (r_idx[3:0] == c_LAST_SHIFT) begin
                    w_state_next = S_UPDATE;
                end
            end
            S_UPDATE:  w_state_next = S_CAPTURE;
            default:   w_state_next = S_CAPTURE;
        endcase
    end

    //------------------------------------------------------------------------
    // Datapath helpers
    //------------------------------------------------------------------------
    assign w_cell = r_snap[r_idx[7:4]][r_idx[3:0]];

    // Add-3 correction applied to every BCD nibble of 5 or more before the
    // shift, so each nibble carries correctly into the next decade.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int n = 0; n < 3; n++) begin
            if (r_bcd[n*4 +: 4] >= 4'd5) begin
                w_bcd_adj[n*4 +: 4] = r_bcd[n*4 +: 4] + 4'd3;
            end
        end
    end

    //------------------------------------------------------------------------
    // Datapath registers
    //------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap  <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_bcd   <= '0;
            r_disp  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_CAPTURE: begin
                    r_snap  <= GrnPixels;
                    r_count <= '0;
                    r_idx   <= '0;
                    r_bcd   <= '0;
                end
                S_COUNT: begin
                    r_count <= r_count + {8'd0, w_cell};
                    r_idx   <= r_idx + 8'd1;
                end
                S_CONVERT: begin
                    // {bcd, binary} shifts left by one as a 21-bit register;
                    // the binary MSB enters the ones nibble.
                    r_bcd   <= {w_bcd_adj[10:0], r_count[8]};
                    r_count <= {r_count[7:0], 1'b0};
                    r_idx   <= r_idx + 8'd1;
                end
                S_UPDATE: begin
                    r_disp  <= r_bcd;
                    r_valid <= 1'b1;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    //------------------------------------------------------------------------
    // Generation counter (3 BCD digits, 999 wraps to 000)
    //------------------------------------------------------------------------
    logic [3:0] r_gen_ones;
    logic [3:0] r_gen_tens;
    logic [3:0] r_gen_hund;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gen_ones <= '0;
            r_gen_tens <= '0;
            r_gen_hund <= '0;
        end else if (gen_tick && !SW_pause) begin
            if (r_gen_ones == 4'd9) begin
                r_gen_ones <= 4'd0;
                if (r_gen_tens == 4'd9) begin
                    r_gen_tens <= 4'd0;
                    if (r_gen_hund == 4'd9) begin
                        r_gen_hund <= 4'd0;
                    end else begin
                        r_gen_hund <= r_gen_hund + 4'd1;
                    end
                end else begin
                    r_gen_tens <= r_gen_tens + 4'd1;
                end
            end else begin
                r_gen_ones <= r_gen_ones + 4'd1;
            end
        end
    end

    //------------------------------------------------------------------------
    // Seven-segment decode (active-low gfedcba)
    //------------------------------------------------------------------------
    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = c_SEG_BLANK;
        endcase
        return s;
    endfunction

    logic w_hund_zero;
    logic w_tens_zero;

    assign w_hund_zero = (r_disp[11:8] == 4'd0);
    assign w_tens_zero = (r_disp[7:4]  == 4'd0);

    // Leading-zero blanking: the ones digit is always shown.
    assign HEX0 = f_seg(r_disp[3:0]);
    assign HEX1 = (w_hund_zero && w_tens_zero) ? c_SEG_BLANK : f_seg(r_disp[7:4]);
    assign HEX2 = w_hund_zero ? c_SEG_BLANK : f_seg(r_disp[11:8]);

    assign HEX3 = f_seg(r_gen_ones);
    assign HEX4 = f_seg(r_gen_tens);
    assign HEX5 = f_seg(r_gen_hund);

    assign stats_valid = r_valid;

endmodule
`default_nettype wire
